// File: rtl/pc_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl_if
// Instruction-memory fetch handshake between pc_fetch_ctrl and instruction
// memory. The controller issues imem_req/imem_addr and waits for imem_ack, which
// marks imem_rdata valid in that cycle. At most one fetch is in flight.
//
// Signals:
//   imem_req    controller -> memory   fetch request
//   imem_addr   controller -> memory   32-bit fetch address, stable until ack
//   imem_ack    memory -> controller   fetch complete, rdata valid this cycle
//   imem_rdata  memory -> controller   32-bit fetched instruction word
//
// Modports:
//   master  fetch controller side
//   slave   instruction memory side
// -----------------------------------------------------------------------------
interface pc_fetch_ctrl_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface : pc_fetch_ctrl_if

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Program-counter and instruction-fetch controller for the single-cycle core.
// Holds the architectural PC, fetches one instruction at a time over a req/ack
// handshake and presents it to decode/execute. When the presented instruction
// retires, the next PC is formed from the jalr/jal/branch controls (jmpb comes
// from branch_ctrl) and the next fetch starts.
//
// Sequencing: IDLE -> FETCH -> EXEC -> FETCH -> ...
//   IDLE   one cycle after reset release
//   FETCH  request outstanding, address held at pc until ack
//   EXEC   instruction presented; retires on the first cycle with hold_i=0
//
// Parameters:
//   RESET_PC   PC loaded by reset
//   TRAP_VEC   redirect target on misaligned control transfer
//              (present only when MISALIGN_TRAP_EN is defined)
//
// Build option:
//   MISALIGN_TRAP_EN  defined: a misaligned retire target redirects to
//                     TRAP_VEC and pulses misalign_o for one cycle.
//                     undefined: target bits [1:0] are cleared, misalign_o=0.
//
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous reset, active-high
//   hold_i         core stall; presented instruction does not retire
//   branch_i       current instruction is a conditional branch
//   jmpb_i         branch condition result from branch_ctrl
//   jal_i          current instruction is JAL
//   jalr_i         current instruction is JALR
//   imm_i          sign-extended immediate of current instruction
//   data_rs1_i     rs1 value for JALR
//   imem           fetch handshake (master modport)
//   instr_o        instruction presented to decode
//   instr_valid_o  instr_o valid; executes this cycle unless hold_i=1
//   pc_o           PC of presented instruction
//   pc_link_o      pc_o + 4 for JAL/JALR writeback
//   misalign_o     one-cycle misaligned-target pulse
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hold_i,
   input  logic                   branch_i,
   input  logic                   jmpb_i,
   input  logic                   jal_i,
   input  logic                   jalr_i,
   input  logic [31:0]            imm_i,
   input  logic [31:0]            data_rs1_i,
   pc_fetch_ctrl_if.master        imem,
   output logic [31:0]            instr_o,
   output logic                   instr_valid_o,
   output logic [31:0]            pc_o,
   output logic [31:0]            pc_link_o,
   output logic                   misalign_o
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] target;

   // --------------------------------------------------------------------------
   // Retire target, priority jalr > jal > taken branch > sequential.
   // Only consumed on a retiring EXEC cycle, so the control inputs are
   // effectively ignored at all other times.
   // --------------------------------------------------------------------------
   always_comb begin
      target = pc_q + 32'd4;
      if (jalr_i) begin
         target = (data_rs1_i + imm_i) & ~32'h1;
      end else if (jal_i || (branch_i && jmpb_i)) begin
         target = pc_q + imm_i;
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
`endif

   // --------------------------------------------------------------------------
   // Next-state and datapath update.
   // NOTE: every signal gets its hold value first so no path through the case
   // leaves one unassigned, which would otherwise infer a latch.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
`ifdef MISALIGN_TRAP_EN
      misalign_d    = 1'b0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            // hold_i is deliberately not looked at here; a stall only
            // freezes an instruction that is already presented.
            if (imem.imem_ack) begin
               instr_d       = imem.imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = ST_EXEC;
            end
         end

         ST_EXEC: begin
            if (!hold_i) begin
               instr_valid_d = 1'b0;
               state_d       = ST_FETCH;
`ifdef MISALIGN_TRAP_EN
               // pc+4 from an aligned pc is always aligned, so only a
               // control transfer can land here.
               if (target[1:0] != 2'b00) begin
                  pc_d       = TRAP_VEC;
                  misalign_d = 1'b1;
               end else begin
                  pc_d       = target;
               end
`else
               pc_d = target & ~32'h3;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers. Reset wins over everything, including an ack that
   // arrives in the same cycle, so an in-flight fetch is simply abandoned.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= NOP_INSTR;
         instr_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
`ifdef MISALIGN_TRAP_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc_q;

   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign pc_o          = pc_q;
   assign pc_link_o     = pc_q + 32'd4;

`ifdef MISALIGN_TRAP_EN
   assign misalign_o = misalign_q;
`else
   assign misalign_o = 1'b0;
`endif

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Scoreboard bench for pc_fetch_ctrl. Stimulus tasks push the expected fetch
// address (with misalign flag) when an instruction is retired, and the expected
// instruction/pc when a word is returned; a monitor pops and compares whenever
// a new fetch request or a newly valid instruction appears.
// Honours MISALIGN_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic        branch;
   logic        jmpb;
   logic        jal;
   logic        jalr;
   logic [31:0] imm;
   logic [31:0] data_rs1;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_link;
   logic        misalign;

   pc_fetch_ctrl_if imem_bus ();

   pc_fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .hold_i        (hold),
      .branch_i      (branch),
      .jmpb_i        (jmpb),
      .jal_i         (jal),
      .jalr_i        (jalr),
      .imm_i         (imm),
      .data_rs1_i    (data_rs1),
      .imem          (imem_bus),
      .instr_o       (instr),
      .instr_valid_o (instr_valid),
      .pc_o          (pc),
      .pc_link_o     (pc_link),
      .misalign_o    (misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        mis;
   } fetch_exp_t;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } exec_exp_t;

   fetch_exp_t  fetch_q[$];
   exec_exp_t   exec_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic req_prev   = 1'b0;
   logic valid_prev = 1'b0;

   always @(negedge clk) begin : monitor
      fetch_exp_t fe;
      exec_exp_t  ee;
      if (imem_bus.imem_req && !req_prev) begin
         if (fetch_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_fetch: got addr %h expected no request", imem_bus.imem_addr);
         end else begin
            fe = fetch_q.pop_front();
            check("fetch_addr", imem_bus.imem_addr, fe.addr);
            check("misalign_pulse", {31'b0, misalign}, {31'b0, fe.mis});
         end
      end
      if (instr_valid && !valid_prev) begin
         if (exec_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got instr %h expected none", instr);
         end else begin
            ee = exec_q.pop_front();
            check("exec_instr", instr, ee.word);
            check("exec_pc", pc, ee.pc);
         end
      end
      req_prev   = imem_bus.imem_req;
      valid_prev = instr_valid;
   end

   // -------------------------------------------------------------- stimulus
   task automatic wait_valid();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!instr_valid && n < 30);
      if (!instr_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_valid: got no instr_valid expected within 30 cycles");
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_bus.imem_req && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!imem_bus.imem_req) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_req: got no imem_req expected within 30 cycles");
      end
   endtask

   // Retire the presented instruction; called at a negedge in EXEC.
   task automatic retire(input logic br, input logic jb, input logic jl, input logic jr,
                         input logic [31:0] im, input logic [31:0] rs1);
      logic [31:0] t;
      logic        mis;
      mis = 1'b0;
      if (jr)             t = (rs1 + im) & ~32'h1;
      else if (jl)        t = model_pc + im;
      else if (br && jb)  t = model_pc + im;
      else                t = model_pc + 32'd4;
`ifdef MISALIGN_TRAP_EN
      if (t[1:0] != 2'b00) begin
         t   = TRAP_VEC;
         mis = 1'b1;
      end
`else
      t = t & ~32'h3;
`endif
      fetch_q.push_back('{addr: t, mis: mis});
      model_pc = t;
      branch   = br;
      jmpb     = jb;
      jal      = jl;
      jalr     = jr;
      imm      = im;
      data_rs1 = rs1;
      hold     = 1'b0;
      @(negedge clk);
      branch   = 1'b0;
      jmpb     = 1'b0;
      jal      = 1'b0;
      jalr     = 1'b0;
      imm      = 32'h0;
      data_rs1 = 32'h0;
      hold     = 1'b1;
      if (mis) begin
         @(negedge clk);
         check("misalign_one_cycle", {31'b0, misalign}, 32'h0);
      end
   endtask

   // Complete the outstanding fetch after 'delay' cycles without ack.
   task automatic fetch(input int delay, input logic [31:0] word);
      logic [31:0] a0;
      exec_q.push_back('{word: word, pc: model_pc});
      wait_req();
      a0 = imem_bus.imem_addr;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         check("req_stable", {31'b0, imem_bus.imem_req}, 32'h1);
         check("addr_stable", imem_bus.imem_addr, a0);
      end
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = word;
      @(negedge clk);
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      check("valid_after_ack", {31'b0, instr_valid}, 32'h1);
   endtask

   initial begin
      rst      = 1'b1;
      hold     = 1'b0;
      branch   = 1'b0;
      jmpb     = 1'b0;
      jal      = 1'b0;
      jalr     = 1'b0;
      imm      = 32'h0;
      data_rs1 = 32'h0;
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = NOP_INSTR;

      // Reset held two cycles with ack already high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
      check("rst_valid", {31'b0, instr_valid}, 32'h0);
      check("rst_pc", pc, RESET_PC);
      check("rst_instr", instr, NOP_INSTR);
      check("rst_misalign", {31'b0, misalign}, 32'h0);

      // Free-running: ack always high, no hold -> pc 0, 4, 8.
      model_pc = RESET_PC;
      for (int i = 0; i < 3; i++) begin
         fetch_q.push_back('{addr: RESET_PC + 32'(i * 4), mis: 1'b0});
         exec_q.push_back('{word: NOP_INSTR, pc: RESET_PC + 32'(i * 4)});
      end
      rst = 1'b0;
      @(negedge clk);
      check("first_req", {31'b0, imem_bus.imem_req}, 32'h1);
      check("first_addr", imem_bus.imem_addr, RESET_PC);
      for (int i = 0; i < 3; i++) begin
         wait_valid();
         check("seq_pc", pc, RESET_PC + 32'(i * 4));
         if (i == 2) begin
            hold = 1'b1;
            imem_bus.imem_ack = 1'b0;
         end
      end
      model_pc = 32'h8;

      // Hold in EXEC for 3 cycles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_pc", pc, 32'h8);
         check("hold_instr", instr, NOP_INSTR);
         check("hold_valid", {31'b0, instr_valid}, 32'h1);
         check("hold_no_req", {31'b0, imem_bus.imem_req}, 32'h0);
      end

      // jal to 0x100, then taken branch -8 with a 5-cycle ack delay.
      retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00F8, 32'h0);
      fetch(0, 32'h0000_0063);
      retire(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
      fetch(5, 32'h0000_0033);

      // Back to 0x100, then not-taken branch -> 0x104.
      retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
      fetch(1, 32'h0000_00B3);
      retire(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
      fetch(2, 32'h0000_0133);

      // To 0x40, then jalr+jal together: jalr wins, bit 0 cleared.
      retire(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF3C, 32'h0);
      fetch(0, 32'h0000_006F);
      check("pc_link_40", pc_link, 32'h44);
      retire(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_2001);
      fetch(0, 32'h0000_0067);

      // Wraparound from 0xFFFF_FFFC.
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
      fetch(0, NOP_INSTR);
      check("pc_link_wrap", pc_link, 32'h0);
      retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      fetch(0, NOP_INSTR);

      // Misaligned jal target 0x102.
      retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0);
      fetch(1, NOP_INSTR);
      check("misalign_pc", pc, 32'h100);

      // Reset in the 2nd FETCH cycle with ack high in the same cycle.
      retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      imem_bus.imem_ack   = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("midrst_valid", {31'b0, instr_valid}, 32'h0);
      check("midrst_pc", pc, RESET_PC);
      check("midrst_req", {31'b0, imem_bus.imem_req}, 32'h0);
      check("midrst_instr", instr, NOP_INSTR);
      model_pc = RESET_PC;
      fetch_q.push_back('{addr: RESET_PC, mis: 1'b0});
      rst = 1'b0;
      @(negedge clk);
      check("idle_ack_ignored", {31'b0, instr_valid}, 32'h0);
      check("restart_req", {31'b0, imem_bus.imem_req}, 32'h1);
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      fetch(0, NOP_INSTR);

      @(negedge clk);
      check("fetch_queue_drained", 32'(fetch_q.size()), 32'h0);
      check("exec_queue_drained", 32'(exec_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pc_fetch_ctrl

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and instruction-fetch controller for the single-cycle core; it sits directly downstream of branch_ctrl and consumes its jmpb output.
- Holds the architectural PC and computes the next PC from jmpb, jal/jalr decode, the immediate and rs1.
- Fetches each instruction over a req/ack handshake to instruction memory.
- Presents one instruction at a time to decode/execute.
- Sequencing is a small FSM so that variable-latency memory and pipeline holds are tolerated.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded by reset.
TRAP_VEC, 32'h0000_0100, redirect target on misaligned control transfer (used only with MISALIGN_TRAP_EN).

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
hold  input  1  core stall; instruction stays presented and is not retired.
branch  input  1  current instruction is a conditional branch.
jmpb  input  1  branch condition result from branch_ctrl.
jal  input  1  current instruction is JAL.
jalr  input  1  current instruction is JALR.
imm  input  32  sign-extended immediate of current instruction.
data_rs1  input  32  rs1 value for JALR.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address; equals pc.
imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  input  32  fetched instruction word.
instr  output  32  instruction presented to decode.
instr_valid  output  1  instr is valid and executes this cycle unless hold=1.
pc  output  32  PC of presented instruction.
pc_link  output  32  pc+4, for JAL/JALR writeback.
misalign  output  1  one-cycle pulse on misaligned target (MISALIGN_TRAP_EN only; tied 0 otherwise).

Behaviour:
- FSM states: IDLE, FETCH, EXEC.
- Reset (rst=1 at an edge, any state):
  - state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - instr_valid=0, imem_req=0, misalign=0.
- Reset mid-fetch: the request is dropped. An ack arriving in the cycle rst=1 is ignored.
- IDLE -> FETCH unconditionally on the next edge. This gives one idle cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc. Address is held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - An ack in the first FETCH cycle is legal, so the minimum is fetch-to-valid = 1 cycle.
  - hold has no effect in FETCH.
- EXEC:
  - imem_req=0, instr_valid=1.
  - If hold=1: remain in EXEC; pc, instr and instr_valid are unchanged.
  - If hold=0: the instruction retires. pc<=next_pc, instr_valid<=0, go to FETCH.
- next_pc, priority jalr > jal > (branch & jmpb) > sequential:
  - jalr: (data_rs1+imm) & ~32'h1
  - jal: pc+imm
  - branch & jmpb: pc+imm
  - otherwise: pc+4
- Arithmetic: all 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- pc_link = pc+4, combinational.
- The branch/jal/jalr/imm/data_rs1 inputs are sampled only in an EXEC cycle with hold=0 and are ignored otherwise.
- No outstanding-request queue: at most one fetch in flight, and ack outside FETCH is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - On retire, if the selected target has next_pc[1:0]!=0, then pc<=TRAP_VEC and misalign pulses high for exactly the following cycle (the first FETCH cycle).
  - Sequential pc+4 can never trigger it.
- Undefined:
  - No check; next_pc[1:0] are forced to 2'b00 before loading pc.
  - misalign is tied 0.

Test Plan:
- rst high 2 cycles, then low; ack held at 1 with rdata=32'h0000_0013 -> imem_req=1 with imem_addr=0 in 2nd cycle after release; instr_valid=1 next cycle; pc sequence 0,4,8 on successive retires.
- pc=32'h100, branch=1, jmpb=1, imm=-8 -> next fetch addr 32'h0F8; same with jmpb=0 -> 32'h104.
- jalr=1 and jal=1 together, data_rs1=32'h2001, imm=4, pc=32'h40 -> next addr 32'h2004; pc_link=32'h44.
- Ack delayed 5 cycles -> imem_req and imem_addr stable for all 5 cycles; hold=1 for 3 cycles in EXEC -> pc/instr unchanged, no new req.
- rst asserted in the 2nd FETCH cycle with imem_ack=1 the same cycle -> instr_valid stays 0, pc=RESET_PC, fetch restarts from IDLE.
- MISALIGN_TRAP_EN defined, jal with pc+imm=32'h102 -> misalign pulses for 1 cycle, next fetch addr 32'h100 (TRAP_VEC). Undefined, same stimulus -> fetch addr 32'h100 (forced alignment), misalign=0.
